// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the scratch-RAM access arbiter.
// State encoding, RAM latency and default geometry.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam int RAM_RD_LAT    = 1;
    localparam int DEF_ADDR_W    = 16;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_MEM_DEPTH = 32768;

endpackage

// File: rtl/ram_access_arbiter_rr_arbiter.sv
// Request picker: round-robin with pointer register by default,
// fixed lowest-index priority when RAM_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               RST,
    input  logic [NUM_REQ-1:0] req,
    input  logic               upd,
    input  logic [IDX_W-1:0]   upd_idx,
    output logic [NUM_REQ-1:0] gnt
);

    logic found;

`ifdef RAM_ARB_FIXED_PRIO_EN

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i]) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

`else

    logic [IDX_W-1:0] ptr;
    int unsigned      pos;

    // Reset points at the last requester so requester 0 is searched first.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            ptr <= IDX_W'(NUM_REQ - 1);
        end else if (upd) begin
            ptr <= upd_idx;
        end
    end

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        pos   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = (int'(ptr) + 1 + i) % NUM_REQ;
            if (!found && req[pos]) begin
                gnt[pos] = 1'b1;
                found    = 1'b1;
            end
        end
    end

`endif

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares the single-port scratch RAM among NUM_REQ requesters.
// Build option RAM_ARB_FIXED_PRIO_EN selects fixed priority.
module ram_access_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
    input  logic                        clk,
    input  logic                        RST,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        rsp_err,
    output logic [ADDR_W-1:0]           mem_address,
    output logic [DATA_W-1:0]           mem_data,
    output logic                        mem_read_signal,
    output logic                        mem_write_signal,
    input  logic [DATA_W-1:0]           mem_dataout
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(MEM_DEPTH);

    arb_state_t       state;
    logic [NUM_REQ-1:0] pick;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] own_idx;
    logic             own_we;
    logic             own_err;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic             sel_we;
    logic             sel_err;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk     (clk),
        .RST     (RST),
        .req     (req),
        .upd     (state == RESP),
        .upd_idx (own_idx),
        .gnt     (pick)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) begin
                pick_idx = IDX_W'(i);
            end
        end
    end

    assign sel_addr  = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
    assign sel_wdata = req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
    assign sel_we    = req_we[pick_idx];
    assign sel_err   = {1'b0, sel_addr} >= DEPTH;

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state            <= IDLE;
            own_idx          <= '0;
            own_we           <= 1'b0;
            own_err          <= 1'b0;
            gnt              <= '0;
            rsp_valid        <= '0;
            rsp_rdata        <= '0;
            rsp_err          <= 1'b0;
            mem_address      <= '0;
            mem_data         <= '0;
            mem_read_signal  <= 1'b0;
            mem_write_signal <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        own_idx <= pick_idx;
                        own_we  <= sel_we;
                        own_err <= sel_err;
                        gnt     <= pick;
                        state   <= ISSUE;
                        // Out-of-range accesses never reach the RAM.
                        if (!sel_err) begin
                            mem_address      <= sel_addr;
                            mem_data         <= sel_wdata;
                            mem_write_signal <= sel_we;
                            mem_read_signal  <= !sel_we;
                        end
                    end
                end
                ISSUE: begin
                    gnt              <= '0;
                    mem_read_signal  <= 1'b0;
                    mem_write_signal <= 1'b0;
                    state            <= CAPT;
                end
                CAPT: begin
                    rsp_rdata <= (!own_we && !own_err) ? mem_dataout : '0;
                    rsp_err   <= own_err;
                    rsp_valid <= NUM_REQ'(1) << own_idx;
                    state     <= RESP;
                end
                RESP: begin
                    rsp_valid <= '0;
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Scoreboard bench for ram_access_arbiter with a behavioural RAM.
module tb_ram_access_arbiter;

    localparam int NR = 2;
    localparam int AW = 16;
    localparam int DW = 8;

    typedef struct {
        int         idx;
        logic [7:0] rd;
        logic       err;
    } rsp_t;

    logic              clk;
    logic              RST;
    logic [NR-1:0]     req;
    logic [NR-1:0]     req_we;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     gnt;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic [AW-1:0]     mem_address;
    logic [DW-1:0]     mem_data;
    logic              mem_read_signal;
    logic              mem_write_signal;
    logic [DW-1:0]     mem_dataout;

    logic [7:0] ram [0:32767];
    int   strobe_cnt;
    int   errors;
    int   checks;
    int   gnt_q[$];
    rsp_t rsp_q[$];

    ram_access_arbiter #(
        .NUM_REQ   (NR),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MEM_DEPTH (32768)
    ) dut (
        .clk              (clk),
        .RST              (RST),
        .req              (req),
        .req_we           (req_we),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .gnt              (gnt),
        .rsp_valid        (rsp_valid),
        .rsp_rdata        (rsp_rdata),
        .rsp_err          (rsp_err),
        .mem_address      (mem_address),
        .mem_data         (mem_data),
        .mem_read_signal  (mem_read_signal),
        .mem_write_signal (mem_write_signal),
        .mem_dataout      (mem_dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial mem_dataout = '0;
    initial strobe_cnt = 0;

    always @(posedge clk) begin
        if (mem_write_signal) ram[mem_address[14:0]] <= mem_data;
        if (mem_read_signal) mem_dataout <= ram[mem_address[14:0]];
        if (mem_read_signal || mem_write_signal) strobe_cnt <= strobe_cnt + 1;
    end

    task automatic chk(input bit ok, input string name,
                       input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents gnt or rsp.
    always @(negedge clk) begin
        if (RST) begin
            if (mem_read_signal || mem_write_signal)
                chk(!(mem_read_signal && mem_write_signal), "strobe_excl",
                    {mem_read_signal, mem_write_signal}, 0);
            if (|gnt) begin
                if (gnt_q.size() == 0) begin
                    chk(0, "gnt_unexpected", gnt, 0);
                end else begin
                    int e;
                    e = gnt_q.pop_front();
                    chk(gnt == NR'(1 << e), "gnt_onehot", gnt, 1 << e);
                end
            end
            if (|rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    chk(0, "rsp_unexpected", rsp_valid, 0);
                end else begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    chk(rsp_valid == NR'(1 << r.idx), "rsp_valid",
                        rsp_valid, 1 << r.idx);
                    chk(rsp_rdata === r.rd, "rsp_rdata", rsp_rdata, r.rd);
                    chk(rsp_err === r.err, "rsp_err", rsp_err, r.err);
                end
            end
        end
    end

    task automatic drive(input int i, input bit we,
                         input logic [15:0] a, input logic [7:0] d);
        req_we[i]          = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic access(input int i, input bit we, input logic [15:0] a,
                          input logic [7:0] d, input logic [7:0] er,
                          input bit ee);
        int sc0;
        int n;
        rsp_t r;
        r.idx = i;
        r.rd  = er;
        r.err = ee;
        gnt_q.push_back(i);
        rsp_q.push_back(r);
        @(negedge clk);
        sc0 = strobe_cnt;
        drive(i, we, a, d);
        req[i] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!gnt[i] && n < 20);
        chk(n == 1, "gnt_latency", n, 1);
        req[i] = 1'b0;
        n = 0;
        while (!rsp_valid[i] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(n == 2, "rsp_latency", n, 2);
        chk(strobe_cnt - sc0 == (ee ? 0 : 1), "strobe_count",
            strobe_cnt - sc0, ee ? 0 : 1);
    endtask

    task automatic push_op(input int i, input logic [7:0] er);
        rsp_t r;
        r.idx = i;
        r.rd  = er;
        r.err = 1'b0;
        gnt_q.push_back(i);
        rsp_q.push_back(r);
    endtask

    initial begin
        int cnt;
        int n;
        int order[4];
        errors    = 0;
        checks    = 0;
        RST       = 1'b0;
        req       = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(negedge clk);
        chk(gnt == 0 && rsp_valid == 0, "reset_gnt_rsp", {gnt, rsp_valid}, 0);
        chk(rsp_rdata == 0 && rsp_err == 0, "reset_rdata_err",
            {rsp_rdata, rsp_err}, 0);
        chk(!mem_read_signal && !mem_write_signal, "reset_strobes",
            {mem_read_signal, mem_write_signal}, 0);
        chk(mem_address == 0 && mem_data == 0, "reset_mem_bus",
            {mem_address, mem_data}, 0);
        RST = 1'b1;

        access(0, 1'b1, 16'h0010, 8'hA5, 8'h00, 1'b0);
        access(0, 1'b0, 16'h0010, 8'h00, 8'hA5, 1'b0);
        access(1, 1'b1, 16'h0020, 8'h5A, 8'h00, 1'b0);
        access(1, 1'b0, 16'h0020, 8'h00, 8'h5A, 1'b0);

`ifdef RAM_ARB_FIXED_PRIO_EN
        order = '{0, 0, 0, 0};
`else
        order = '{0, 1, 0, 1};
`endif
        for (int k = 0; k < 4; k++)
            push_op(order[k], order[k] == 0 ? 8'hA5 : 8'h5A);
        push_op(1, 8'h5A);
        @(negedge clk);
        drive(0, 1'b0, 16'h0010, 8'h00);
        drive(1, 1'b0, 16'h0020, 8'h00);
        req = 2'b11;
        cnt = 0;
        n   = 0;
        while (cnt < 5 && n < 60) begin
            @(negedge clk);
            n++;
            if (|rsp_valid) begin
                cnt++;
                if (cnt == 4) req[0] = 1'b0;
                if (cnt == 5) req[1] = 1'b0;
            end
        end
        chk(cnt == 5, "contention_ops", cnt, 5);

        access(1, 1'b0, 16'h8000, 8'h00, 8'h00, 1'b1);
        access(1, 1'b1, 16'hFFFF, 8'h77, 8'h00, 1'b1);

        access(0, 1'b1, 16'h0005, 8'h3C, 8'h00, 1'b0);
        access(0, 1'b0, 16'h0005, 8'h00, 8'h3C, 1'b0);

        gnt_q.push_back(0);
        @(negedge clk);
        drive(0, 1'b0, 16'h0010, 8'h00);
        req[0] = 1'b1;
        @(negedge clk);
        req[0] = 1'b0;
        @(negedge clk);
        RST = 1'b0;
        #1;
        chk(gnt == 0 && rsp_valid == 0 && rsp_rdata == 0 && rsp_err == 0,
            "midop_reset_rsp", {gnt, rsp_valid, rsp_rdata, rsp_err}, 0);
        chk(!mem_read_signal && !mem_write_signal && mem_address == 0,
            "midop_reset_mem", {mem_read_signal, mem_write_signal, mem_address}, 0);
        @(negedge clk);
        RST = 1'b1;

        push_op(0, 8'hA5);
        push_op(1, 8'h5A);
        @(negedge clk);
        drive(0, 1'b0, 16'h0010, 8'h00);
        drive(1, 1'b0, 16'h0020, 8'h00);
        req = 2'b11;
        cnt = 0;
        n   = 0;
        while (cnt < 2 && n < 40) begin
            @(negedge clk);
            n++;
            if (|rsp_valid) begin
                cnt++;
                if (cnt == 1) req[0] = 1'b0;
                if (cnt == 2) req[1] = 1'b0;
            end
        end
        chk(cnt == 2, "post_reset_ops", cnt, 2);

        repeat (4) @(negedge clk);
        chk(gnt_q.size() == 0, "gnt_q_drained", gnt_q.size(), 0);
        chk(rsp_q.size() == 0, "rsp_q_drained", rsp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
- Sequences and shares the single-port 8-bit scratch RAM between NUM_REQ requesters, such as the IO loader writing input feature maps and the convolution engine reading them.
- Arbitrates, latches one request, and drives the RAM's address/data/read/write strobes with the RAM's fixed one-clock registered access.
- Returns read data or a write acknowledge to the owning requester.
- Sits between requester masters and the RAM instance in the IO module top.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 16, RAM address width.
- DATA_W, 8, RAM data width.
- MEM_DEPTH, 32768, valid word count; addresses >= MEM_DEPTH are errors.

Ports:
- clk  in  1  single clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester request level.
- req_we  in  NUM_REQ  1=write, 0=read.
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i at bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  flattened write data.
- gnt  out  NUM_REQ  one-hot, one-cycle grant pulse.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse.
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid.
- rsp_err  out  1  out-of-range flag, valid with rsp_valid.
- mem_address  out  ADDR_W  to RAM address.
- mem_data  out  DATA_W  to RAM write data.
- mem_read_signal  out  1  RAM read strobe.
- mem_write_signal  out  1  RAM write strobe.
- mem_dataout  in  DATA_W  RAM read data.

Behaviour:
- Reset (RST=0, asynchronous):
  - All outputs go to 0 and the FSM enters IDLE.
  - The round-robin pointer resets so requester 0 has highest priority.
  - A reset mid-operation aborts the operation with no rsp_valid; a strobe already sampled by the RAM is not undone.
- FSM states: IDLE, ISSUE, CAPT, RESP. All outputs are registered.
- IDLE:
  - If any req bit is set, pick the winner by round-robin, searching from (last winner + 1) mod NUM_REQ.
  - Latch the winner's index, we, addr and wdata.
  - Next cycle: gnt[winner]=1 and state ISSUE.
  - If the latched address is in range, mem_address/mem_data are driven and the matching strobe is 1 in ISSUE.
  - If no req is set, stay in IDLE with all strobes 0.
- ISSUE:
  - The RAM samples the strobe at this edge.
  - Next state CAPT; gnt and strobes return to 0.
  - mem_address holds the latched value until IDLE.
- CAPT:
  - mem_dataout is stable.
  - For reads, register mem_dataout into rsp_rdata; for writes, rsp_rdata=0.
  - Next state RESP.
- RESP:
  - rsp_valid[owner]=1 for exactly one cycle.
  - Update the round-robin pointer to the owner.
  - Next state IDLE.
- Latency: req sampled in IDLE at cycle N -> gnt in N+1 -> rsp_valid in N+3. Throughput is one access per 4 cycles.
- Error case: latched addr >= MEM_DEPTH means no strobe in ISSUE, and RESP gives rsp_err=1 with rsp_rdata=0.
- Requester handshake:
  - The requester may drop req after gnt; the latched operation still completes.
  - A req still high in RESP is re-arbitrated in the following IDLE.
- Simultaneous requests: exactly one gnt is issued; the others wait in IDLE with no starvation, since every requester is served within NUM_REQ operations.
- mem_read_signal and mem_write_signal are never both 1.

Optional Feature:
- Macro: RAM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; the round-robin pointer is removed.
- Undefined: round-robin as above.

Decomposition:
- Shared package/include ram_arb_pkg holds:
  - FSM state encoding (IDLE=2'd0, ISSUE=2'd1, CAPT=2'd2, RESP=2'd3).
  - RAM read latency constant RAM_RD_LAT=1.
  - Default ADDR_W/DATA_W/MEM_DEPTH.
- One sub-module: rr_arbiter, with NUM_REQ request vector, pointer in, and one-hot grant out. It is combinational pick logic plus the pointer register, and contains the fixed-priority macro switch.

Test Plan:
- Write/read single requester: req0 we=1 addr=0x0010 wdata=0xA5; then read addr=0x0010 -> gnt0 one cycle after req; rsp_valid[0] 3 cycles after req; rsp_rdata=0xA5; rsp_err=0.
- Contention: req0 and req1 both continuously reading different addresses -> grants alternate 0,1,0,1; each rsp_valid is one cycle long; never two gnt bits set together.
- Out of range: req1 read addr=0x8000 -> no mem strobe in any cycle; rsp_valid[1] with rsp_err=1 and rsp_rdata=0x00.
- Early drop: req0 write 0x3C to 0x0005, with req deasserted the cycle after gnt -> write strobe still issued once; rsp_valid[0] pulses; a later read returns 0x3C.
- Reset mid-operation: assert RST=0 in CAPT -> all outputs 0 immediately with no rsp_valid; after release, req0 and req1 together -> gnt0 first.
- With RAM_ARB_FIXED_PRIO_EN defined, req0 and req1 held continuously -> only gnt0 is issued; req1 is granted only after req0 drops.
